// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/control/data payload, hazard
// stall (hold) and flush (bubble) controls, a small occupancy FSM and
// saturating stall/flush/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned CTRL_W     = 12,
  parameter int unsigned FLUSH_DATA = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic              held,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_VALID = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_held;
  logic                w_held_nxt;
  logic                r_valid;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic [CNT_W-1:0]    r_bubble_cnt;
  logic                w_stall_inc;
  logic                w_flush_inc;
  logic                w_bubble_inc;

  // Occupancy state register; held is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // Next-state decode: flush empties, stall holds (a stalled bubble stays empty), load follows valid_in.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else if (stall) begin
      case (r_state)
        S_VALID: w_state_nxt = S_HELD;
        S_HELD:  w_state_nxt = S_HELD;
        default: w_state_nxt = S_EMPTY;
      endcase
    end else begin
      w_state_nxt = valid_in ? S_VALID : S_EMPTY;
    end
    w_held_nxt = (w_state_nxt == S_HELD);
  end

  // Payload register: flush > stall > load; an invalid entry never carries control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (FLUSH_DATA != 0) begin
        r_data <= '0;
      end
    end else if (!stall) begin
      r_valid <= valid_in;
      r_ctrl  <= valid_in ? ctrl_in : '0;
      r_data  <= data_in;
    end
  end

  assign w_stall_inc  = stall & ~flush;
  assign w_flush_inc  = flush;
  assign w_bubble_inc = flush | (~stall & ~valid_in);

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_bubble_inc && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_out  = r_valid;
  assign ctrl_out   = r_ctrl;
  assign data_out   = r_data;
  assign held       = r_held;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances share the stimulus,
// one holding data on flush with 3-bit counters, one zeroing data on flush
// with 32-bit counters.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 256;
  localparam int unsigned CW = 12;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;
  logic          stall;
  logic          flush;
  logic          cnt_clr;

  logic          v0, h0, v1, h1;
  logic [CW-1:0] c0, c1;
  logic [DW-1:0] d0, d1;
  logic [2:0]    sc0, fc0, bc0;
  logic [31:0]   sc1, fc1, bc1;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(0), .CNT_W(3)) u_dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .valid_out(v0), .ctrl_out(c0), .data_out(d0), .held(h0),
    .stall_cnt(sc0), .flush_cnt(fc0), .bubble_cnt(bc0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .valid_out(v1), .ctrl_out(c1), .data_out(d1), .held(h1),
    .stall_cnt(sc1), .flush_cnt(fc1), .bubble_cnt(bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          h;
    int unsigned   sc0, fc0, bc0;
    int unsigned   sc1, fc1, bc1;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          m_v;
  logic [CW-1:0] m_c;
  logic [DW-1:0] m_d0, m_d1;
  int            m_st;   // 0 empty, 1 valid, 2 held
  int unsigned   m_sc0, m_fc0, m_bc0, m_sc1, m_fc1, m_bc1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned x, input int unsigned mx);
    return (x < mx) ? x + 1 : mx;
  endfunction

  // Drive one cycle, push the model's expected result, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input logic s, input logic f, input logic clr);
    exp_t e;
    @(negedge clk);
    rst = r; valid_in = v; ctrl_in = c; data_in = d; stall = s; flush = f; cnt_clr = clr;
    if (r) begin
      m_v = 1'b0; m_c = '0; m_d0 = '0; m_d1 = '0; m_st = 0;
      m_sc0 = 0; m_fc0 = 0; m_bc0 = 0; m_sc1 = 0; m_fc1 = 0; m_bc1 = 0;
    end else begin
      if (clr) begin
        m_sc0 = 0; m_fc0 = 0; m_bc0 = 0; m_sc1 = 0; m_fc1 = 0; m_bc1 = 0;
      end else begin
        if (s && !f) begin m_sc0 = sat_inc(m_sc0, 7); m_sc1 = sat_inc(m_sc1, 32'hFFFF_FFFF); end
        if (f)       begin m_fc0 = sat_inc(m_fc0, 7); m_fc1 = sat_inc(m_fc1, 32'hFFFF_FFFF); end
        if (f || (!s && !v)) begin m_bc0 = sat_inc(m_bc0, 7); m_bc1 = sat_inc(m_bc1, 32'hFFFF_FFFF); end
      end
      if (f) begin
        m_v = 1'b0; m_c = '0; m_d1 = '0; m_st = 0;
      end else if (s) begin
        m_st = (m_st == 0) ? 0 : 2;
      end else begin
        m_v = v; m_c = v ? c : '0; m_d0 = d; m_d1 = d; m_st = v ? 1 : 0;
      end
    end
    e.v = m_v; e.c = m_c; e.d0 = m_d0; e.d1 = m_d1; e.h = (m_st == 2);
    e.sc0 = m_sc0; e.fc0 = m_fc0; e.bc0 = m_bc0;
    e.sc1 = m_sc1; e.fc1 = m_fc1; e.bc1 = m_bc1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", DW'(1), DW'(0));
    end else begin
      e = sb.pop_front();
      check_eq("valid_out0",  DW'(v0),  DW'(e.v));
      check_eq("valid_out1",  DW'(v1),  DW'(e.v));
      check_eq("ctrl_out0",   DW'(c0),  DW'(e.c));
      check_eq("ctrl_out1",   DW'(c1),  DW'(e.c));
      check_eq("data_out0",   d0,       e.d0);
      check_eq("data_out1",   d1,       e.d1);
      check_eq("held0",       DW'(h0),  DW'(e.h));
      check_eq("held1",       DW'(h1),  DW'(e.h));
      check_eq("stall_cnt0",  DW'(sc0), DW'(e.sc0));
      check_eq("flush_cnt0",  DW'(fc0), DW'(e.fc0));
      check_eq("bubble_cnt0", DW'(bc0), DW'(e.bc0));
      check_eq("stall_cnt1",  DW'(sc1), DW'(e.sc1));
      check_eq("flush_cnt1",  DW'(fc1), DW'(e.fc1));
      check_eq("bubble_cnt1", DW'(bc1), DW'(e.bc1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] pa, pb, pr;
    logic [CW-1:0] cr;
    rst = 1'b1; valid_in = 1'b0; ctrl_in = '0; data_in = '0;
    stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    pa = {8{32'hA5A5_0001}};
    pb = {8{32'h5A5A_1002}};

    // T1 reset with stall and flush asserted
    step(1, 1, 12'hFFF, pa, 1, 1, 0);
    step(1, 1, 12'hFFF, pa, 1, 1, 0);
    check_eq("t1_valid", DW'(v0), DW'(0));
    check_eq("t1_data",  d0, DW'(0));
    check_eq("t1_held",  DW'(h0), DW'(0));

    // T2 load
    step(0, 1, 12'h8A1, pa, 0, 0, 0);
    check_eq("t2_valid", DW'(v0), DW'(1));
    check_eq("t2_ctrl",  DW'(c0), DW'(12'h8A1));
    check_eq("t2_data",  d0, pa);

    // T3 stall three cycles with new inputs, then release
    for (int i = 0; i < 3; i++) step(0, 1, 12'h123, pb, 1, 0, 0);
    check_eq("t3_hold_data", d0, pa);
    check_eq("t3_hold_ctrl", DW'(c0), DW'(12'h8A1));
    check_eq("t3_held",      DW'(h0), DW'(1));
    check_eq("t3_stall_cnt", DW'(sc0), DW'(3));
    step(0, 1, 12'h123, pb, 0, 0, 0);
    check_eq("t3_release_data", d0, pb);
    check_eq("t3_release_held", DW'(h0), DW'(0));

    // T4 flush wins over stall
    step(0, 1, 12'h456, pa, 1, 1, 0);
    check_eq("t4_valid",     DW'(v0), DW'(0));
    check_eq("t4_ctrl",      DW'(c0), DW'(0));
    check_eq("t4_data_hold", d0, pb);
    check_eq("t4_data_zero", d1, DW'(0));
    check_eq("t4_flush_cnt", DW'(fc0), DW'(1));
    check_eq("t4_stall_cnt", DW'(sc0), DW'(3));

    // T5 invalid load never carries control
    step(0, 0, 12'hFFF, pa, 0, 0, 0);
    check_eq("t5_ctrl",   DW'(c0), DW'(0));
    check_eq("t5_bubble", DW'(bc0), DW'(2));
    check_eq("t5_held",   DW'(h0), DW'(0));

    // Back-to-back flushes
    step(0, 1, 12'h001, pa, 0, 1, 0);
    step(0, 1, 12'h001, pa, 0, 1, 0);
    check_eq("b2b_valid",     DW'(v0), DW'(0));
    check_eq("b2b_flush_cnt", DW'(fc1), DW'(3));

    // T6 saturation and clear
    step(0, 1, 12'h0F0, pa, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 12'h0F0, pb, 1, 0, 0);
    check_eq("t6_sat",      DW'(sc0), DW'(7));
    check_eq("t6_wide",     DW'(sc1), DW'(10));
    step(0, 1, 12'h0F0, pb, 1, 0, 1);
    check_eq("t6_clr",      DW'(sc0), DW'(0));
    check_eq("t6_clr_data", d0, pa);

    // Reset mid-stall
    step(1, 1, 12'h777, pb, 1, 0, 0);
    check_eq("rst_mid_valid", DW'(v0), DW'(0));
    check_eq("rst_mid_held",  DW'(h0), DW'(0));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      pr = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      cr = 12'($urandom());
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), cr, pr,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 25) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
